// File: rtl/shift_unit_seq_if.sv
// Handshake and data bundle for the multi-cycle shifter.
// The hazard/execute logic drives the master side; the shifter is the slave.
interface shift_unit_seq_if #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
);
   logic               start_i;
   logic [1:0]         op_i;
   logic [WIDTH-1:0]   data_i;
   logic [SHAMT_W-1:0] shamt_i;
   logic               flush_i;
   logic               ready_o;
   logic               busy_o;
   logic               done_o;
   logic [WIDTH-1:0]   result_o;

   modport master (
      output start_i, op_i, data_i, shamt_i, flush_i,
      input  ready_o, busy_o, done_o, result_o
   );

   modport slave (
      input  start_i, op_i, data_i, shamt_i, flush_i,
      output ready_o, busy_o, done_o, result_o
   );
endinterface

// File: rtl/shift_unit_seq.sv
// Multi-cycle SLL/SRL/SRA/ROTR shifter; moves at most STEP bits per cycle
// with start/done handshake and flush abort.
module shift_unit_seq #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5,
   parameter int STEP    = 4
) (
   input logic              clk,
   input logic              rst_n,
   shift_unit_seq_if.slave  bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

   // Largest per-cycle shift that can actually occur (rem never reaches WIDTH).
   localparam int SMAX = (STEP < WIDTH) ? STEP : WIDTH - 1;

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   work, work_sh, result;
   logic [SHAMT_W-1:0] rem, s;
   logic [1:0]         op;
   logic               accept, last;

   assign accept = (state == IDLE) && bus.start_i && !bus.flush_i;
   assign s      = (int'(rem) > SMAX) ? SHAMT_W'(SMAX) : rem;
   assign last   = (rem == s);

   // One small mux per legal step size keeps the per-cycle depth bounded by STEP.
   always_comb begin
      work_sh = work;
      for (int k = 1; k <= SMAX; k++) begin
         if (int'(s) == k) begin
            case (op)
               2'b00:   work_sh = work << k;
               2'b01:   work_sh = work >> k;
               2'b10:   work_sh = $signed(work) >>> k;
               default: work_sh = (work >> k) | (work << (WIDTH - k));
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = (bus.shamt_i == '0) ? DONE : SHIFT;
         SHIFT: begin
            if (bus.flush_i) state_nxt = IDLE;
            else if (last)   state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work   <= '0;
         rem    <= '0;
         op     <= '0;
         result <= '0;
      end else if (accept) begin
         if (bus.shamt_i == '0) begin
            result <= bus.data_i;
         end else begin
            work <= bus.data_i;
            rem  <= bus.shamt_i;
            op   <= bus.op_i;
         end
      end else if (state == SHIFT && !bus.flush_i) begin
         work <= work_sh;
         rem  <= rem - s;
         if (last) result <= work_sh;
      end
   end

   assign bus.ready_o  = (state == IDLE);
   assign bus.busy_o   = (state == SHIFT);
   assign bus.done_o   = (state == DONE);
   assign bus.result_o = result;
endmodule

// File: tb/tb_shift_unit_seq.sv
// Drives STEP=4, STEP=1 and STEP=32 shifters in lockstep and checks results
// and latencies against an arithmetic reference model.
module tb_shift_unit_seq;
   localparam int W = 32;

   logic        clk, rst_n;
   logic [2:0]  start;
   logic [1:0]  op_r;
   logic [31:0] data_r;
   logic [4:0]  shamt_r;
   logic        flush;
   int          errors = 0, checks = 0;
   logic [31:0] res_last [3];
   logic [31:0] last_exp [3];

   shift_unit_seq_if #(.WIDTH(W), .SHAMT_W(5)) b0 ();
   shift_unit_seq_if #(.WIDTH(W), .SHAMT_W(5)) b1 ();
   shift_unit_seq_if #(.WIDTH(W), .SHAMT_W(5)) b2 ();

   shift_unit_seq #(.WIDTH(W), .SHAMT_W(5), .STEP(4))  u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
   shift_unit_seq #(.WIDTH(W), .SHAMT_W(5), .STEP(1))  u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   shift_unit_seq #(.WIDTH(W), .SHAMT_W(5), .STEP(32)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

   assign b0.start_i = start[0];
   assign b1.start_i = start[1];
   assign b2.start_i = start[2];
   assign {b0.op_i, b1.op_i, b2.op_i}          = {3{op_r}};
   assign {b0.data_i, b1.data_i, b2.data_i}    = {3{data_r}};
   assign {b0.shamt_i, b1.shamt_i, b2.shamt_i} = {3{shamt_r}};
   assign {b0.flush_i, b1.flush_i, b2.flush_i} = {3{flush}};

   logic [2:0]  ready_v, busy_v, done_v;
   logic [31:0] res_v [3];
   assign ready_v = {b2.ready_o, b1.ready_o, b0.ready_o};
   assign busy_v  = {b2.busy_o, b1.busy_o, b0.busy_o};
   assign done_v  = {b2.done_o, b1.done_o, b0.done_o};
   assign res_v[0] = b0.result_o;
   assign res_v[1] = b1.result_o;
   assign res_v[2] = b2.result_o;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int step_of(input int k);
      case (k)
         0:       return 4;
         1:       return 1;
         default: return 32;
      endcase
   endfunction

   function automatic int nshift(input int sh, input int k);
      return (sh + step_of(k) - 1) / step_of(k);
   endfunction

   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d, input int sh);
      logic [63:0] w;
      case (op)
         2'b00: return d << sh;
         2'b01: return d >> sh;
         2'b10: begin w = {{32{d[31]}}, d}; w = w >> sh; return w[31:0]; end
         default: begin w = {d, d}; w = w >> sh; return w[31:0]; end
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      for (int c = 0; c < 100 && ready_v != 3'b111; c++) tick();
      if (ready_v != 3'b111) chk("ready_timeout", ready_v, 3'b111);
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh, input string tag);
      int lat [3], bsy [3];
      bit got [3];
      logic [31:0] r [3];
      logic [31:0] e;
      wait_ready();
      op_r = op; data_r = d; shamt_r = sh; start = 3'b111;
      tick();
      start = '0;
      op_r = 2'($urandom); data_r = $urandom; shamt_r = 5'($urandom);
      for (int k = 0; k < 3; k++) begin lat[k] = 0; bsy[k] = 0; got[k] = 0; r[k] = '0; end
      for (int c = 1; c <= 60; c++) begin
         for (int k = 0; k < 3; k++) begin
            if (!got[k] && busy_v[k]) bsy[k]++;
            if (!got[k] && done_v[k]) begin got[k] = 1; lat[k] = c; r[k] = res_v[k]; end
         end
         if (got[0] && got[1] && got[2]) break;
         tick();
      end
      e = model(op, d, int'(sh));
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s_lat[%0d]", tag, k), lat[k], 1 + nshift(int'(sh), k));
         chk($sformatf("%s_busy[%0d]", tag, k), bsy[k], nshift(int'(sh), k));
         chk($sformatf("%s_res[%0d]", tag, k), r[k], e);
         res_last[k] = r[k];
         last_exp[k] = e;
      end
      tick();
      chk($sformatf("%s_ready_after", tag), ready_v, 3'b111);
   endtask

   initial begin
      int nd [3], t1 [3], t2 [3];
      logic [31:0] r1 [3], r2 [3];
      rst_n = 1'b0; start = '0; op_r = '0; data_r = '0; shamt_r = '0; flush = 1'b0;
      for (int k = 0; k < 3; k++) begin res_last[k] = '0; last_exp[k] = '0; end
      #12;
      chk("rst_ready", ready_v, 3'b111);
      chk("rst_busy", busy_v, 3'b000);
      chk("rst_done", done_v, 3'b000);
      chk("rst_result", res_v[0], 32'h0);
      rst_n = 1'b1;
      tick();

      run_op(2'b00, 32'h0000_0001, 5'd2, "t1_sll");
      chk("t1_const", res_last[0], 32'h0000_0004);
      run_op(2'b10, 32'h8000_0000, 5'd31, "t2_sra");
      chk("t2_sra_const", res_last[0], 32'hFFFF_FFFF);
      run_op(2'b01, 32'h8000_0000, 5'd31, "t2_srl");
      chk("t2_srl_const", res_last[0], 32'h0000_0001);
      run_op(2'b11, 32'h1234_5678, 5'd8, "t3_rotr8");
      chk("t3_rotr8_const", res_last[0], 32'h7812_3456);
      run_op(2'b11, 32'h1234_5678, 5'd0, "t3_rotr0");
      chk("t3_rotr0_const", res_last[0], 32'h1234_5678);

      // start held high through SHIFT/DONE: second request waits for IDLE
      wait_ready();
      op_r = 2'b00; data_r = 32'hDEAD_BEEF; shamt_r = 5'd5; start = 3'b111;
      tick();
      data_r = 32'h0000_0001;
      for (int k = 0; k < 3; k++) begin nd[k] = 0; t1[k] = 0; t2[k] = 0; r1[k] = '0; r2[k] = '0; end
      for (int c = 1; c <= 120; c++) begin
         for (int k = 0; k < 3; k++) begin
            if (done_v[k] && nd[k] < 2) begin
               nd[k]++;
               if (nd[k] == 1) begin t1[k] = c; r1[k] = res_v[k]; end
               else begin t2[k] = c; r2[k] = res_v[k]; start[k] = 1'b0; end
            end
         end
         if (nd[0] == 2 && nd[1] == 2 && nd[2] == 2) break;
         tick();
      end
      start = '0;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("t4_first_res[%0d]", k), r1[k], 32'hD5B7_DDE0);
         chk($sformatf("t4_first_lat[%0d]", k), t1[k], 1 + nshift(5, k));
         chk($sformatf("t4_second_res[%0d]", k), r2[k], 32'h0000_0020);
         chk($sformatf("t4_second_gap[%0d]", k), t2[k] - t1[k], 2 + nshift(5, k));
         last_exp[k] = 32'h0000_0020;
      end

      // flush in the second cycle after acceptance
      wait_ready();
      op_r = 2'b01; data_r = 32'hFFFF_0000; shamt_r = 5'd20; start = 3'b111;
      tick();
      start = '0;
      tick();
      flush = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("t5_done_c2[%0d]", k), done_v[k], nshift(20, k) < 2);
         if (nshift(20, k) < 2) last_exp[k] = model(2'b01, 32'hFFFF_0000, 20);
      end
      tick();
      flush = 1'b0;
      chk("t5_ready", ready_v, 3'b111);
      chk("t5_busy", busy_v, 3'b000);
      for (int k = 0; k < 3; k++) chk($sformatf("t5_hold[%0d]", k), res_v[k], last_exp[k]);
      for (int c = 0; c < 3; c++) begin
         chk("t5_no_done", done_v, 3'b000);
         tick();
      end
      run_op(2'b00, 32'h0000_00F0, 5'd3, "t5_after");

      // start under flush in IDLE is dropped
      start = 3'b111; flush = 1'b1;
      tick();
      start = '0; flush = 1'b0;
      chk("idle_flush_ready", ready_v, 3'b111);
      chk("idle_flush_busy", busy_v | done_v, 3'b000);

      // asynchronous reset between edges while shifting
      op_r = 2'b10; data_r = 32'h8000_0000; shamt_r = 5'd31; start = 3'b111;
      tick();
      start = '0;
      tick();
      #3 rst_n = 1'b0;
      #1;
      chk("t6_ready", ready_v, 3'b111);
      chk("t6_busy", busy_v, 3'b000);
      chk("t6_done", done_v, 3'b000);
      for (int k = 0; k < 3; k++) chk($sformatf("t6_res[%0d]", k), res_v[k], 32'h0);
      #2 rst_n = 1'b1;
      tick();
      chk("t6_no_done", done_v, 3'b000);
      run_op(2'b00, 32'h0000_0003, 5'd1, "t6_sll");
      chk("t6_const", res_last[0], 32'h0000_0006);

      for (int i = 0; i < 40; i++)
         run_op(2'($urandom), $urandom, 5'($urandom_range(0, 31)), $sformatf("rnd%0d", i));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/shift_unit_seq.md
Name: shift_unit_seq

Overview:
- Parametrised multi-cycle shifter for the MIPS execute stage. It generalises the fixed left-shift-by-2 used for branch offsets.
- Supports SLL, SRL, SRA and ROTR with a runtime shift amount, and shifts at most STEP bits per cycle to bound logic depth.
- Uses a start/done handshake and a flush input so the hazard unit can stall or kill it.

Parameters:
- WIDTH, 32, datapath width in bits (>=2).
- SHAMT_W, 5, shift-amount width; must equal clog2(WIDTH).
- STEP, 4, maximum bits shifted per cycle; 1..WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  request; accepted only when ready_o=1.
- op_i  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROTR; sampled at acceptance.
- data_i  input  WIDTH  operand; sampled at acceptance.
- shamt_i  input  SHAMT_W  shift amount 0..WIDTH-1; sampled at acceptance.
- flush_i  input  1  synchronous abort of an in-flight operation.
- ready_o  output  1  high in IDLE.
- busy_o  output  1  high in SHIFT.
- done_o  output  1  one-cycle pulse; result_o is valid while it is high.
- result_o  output  WIDTH  last completed result; held until the next completion.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, result_o=0, done_o=0, busy_o=0, ready_o=1. Internal working register and remaining-count register are cleared. Reset mid-operation discards the operation; no done_o is produced.
- States: IDLE, SHIFT, DONE.
- ready_o=(state==IDLE), busy_o=(state==SHIFT), done_o=(state==DONE). All are decoded from registered state.
- IDLE, start_i=1, flush_i=0:
  - shamt_i=0: next state DONE, result_o<=data_i.
  - otherwise: latch data_i into the working register, shamt_i into rem, op_i into the op register; next state SHIFT.
- SHIFT, each cycle:
  - s = min(rem, STEP); shift the working register by s per the latched op; rem <= rem - s.
  - When rem-s==0: result_o <= shifted value; next state DONE.
- DONE: lasts exactly one cycle, then unconditionally returns to IDLE. start_i in DONE is ignored; the earliest next acceptance is the following IDLE cycle.
- Latency: done_o rises 1+ceil(shamt/STEP) cycles after the accepting edge's cycle. With STEP=4: shamt=0 gives 1, shamt=31 gives 9.
- Throughput: one operation per (latency+1) cycles.
- start_i while busy_o=1 or done_o=1 is ignored; there is no queueing.
- Arithmetic rules:
  - SLL fills zeros from the LSB.
  - SRL fills zeros from the MSB.
  - SRA replicates the operand's original MSB. The working-register MSB is preserved across steps, so multi-step SRA equals a single arithmetic shift.
  - ROTR moves bits shifted out of the LSB into the MSB.
  - All results are truncated to WIDTH. shamt_i < WIDTH by construction, so there is no overflow handling.
- flush_i=1 has highest priority:
  - In SHIFT: next state IDLE, result_o unchanged, no done_o.
  - In IDLE: start_i is ignored.
  - In DONE: the completing pulse still occurs (the result was already committed).
- op_i, data_i and shamt_i may change freely after acceptance without affecting the in-flight operation.

Test Plan:
1. Reset then SLL, data_i=0x0000_0001, shamt_i=2 (STEP=4) -> done_o high 2 cycles after acceptance, result_o=0x0000_0004, ready_o back high the next cycle.
2. SRA data_i=0x8000_0000 shamt_i=31 -> busy_o high 8 cycles, done_o at cycle 9, result_o=0xFFFF_FFFF. SRL with the same inputs -> result_o=0x0000_0001.
3. ROTR data_i=0x1234_5678 shamt_i=8 -> done_o at cycle 3, result_o=0x7812_3456. ROTR shamt_i=0 -> done_o the next cycle, result_o=0x1234_5678.
4. SLL 0xDEAD_BEEF shamt_i=5 with a second start_i (data 0x1) held high through SHIFT and DONE -> only the first completes (result_o=0xD5B7_DDE0). The second is accepted in the following IDLE cycle and completes with 0x0000_0020.
5. SRL 0xFFFF_0000 shamt_i=20, flush_i pulsed on the 2nd SHIFT cycle -> no done_o, state IDLE next cycle, result_o retains its prior value. A new start is accepted the following cycle.
6. rst_n driven low asynchronously mid-SHIFT (between clock edges) -> outputs go to reset values immediately. After release, an SLL 0x3 shamt 1 yields 0x6 at cycle 2. Repeat test 2 with STEP=1 and with STEP=32 (latencies 32 and 2), expecting identical results.
